// File: rtl/region_pkg.sv
// Shared constants, FSM encoding and address check for the region boundary bank controller.
package region_pkg;
  localparam int NPOINTS = 812;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam logic [15:0] DISABLED_DIST = 16'hFFFF;
  localparam logic [DW-1:0] FILL_VALUE = {2'b00, DISABLED_DIST};

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARMED = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  // Region 3 does not exist; addresses past the last point are unbacked.
  function automatic logic addr_ok(input logic [1:0] region, input logic [AW-1:0] addr);
    return (region != 2'd3) && (addr < AW'(NPOINTS));
  endfunction
endpackage

// File: rtl/region_rd_pipe.sv
// Host readback return path: carries valid/region/override for RD_LAT cycles and
// selects the matching region's RAM output (or the fill word for illegal requests).
module region_rd_pipe
  import region_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [1:0]    i_region,
  input  logic          i_ovr,
  input  logic [DW-1:0] i_rddata0,
  input  logic [DW-1:0] i_rddata1,
  input  logic [DW-1:0] i_rddata2,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);
  logic [RD_LAT-1:0] r_vld_p;
  logic [RD_LAT-1:0] r_ovr_p;
  logic [1:0]        r_region_p [RD_LAT];
  logic [DW-1:0]     w_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_ovr_p[0]    <= i_ovr;
    r_region_p[0] <= i_region;
    for (int i = 1; i < RD_LAT; i++) begin
      r_ovr_p[i]    <= r_ovr_p[i-1];
      r_region_p[i] <= r_region_p[i-1];
    end
  end

  always_comb begin
    w_sel = FILL_VALUE;
    case (r_region_p[RD_LAT-1])
      2'd0:    w_sel = i_rddata0;
      2'd1:    w_sel = i_rddata1;
      2'd2:    w_sel = i_rddata2;
      default: w_sel = FILL_VALUE;
    endcase
  end

  assign o_vld  = r_vld_p[RD_LAT-1];
  assign o_data = !o_vld ? '0 : (r_ovr_p[RD_LAT-1] ? FILL_VALUE : w_sel);
endmodule

// File: rtl/region_bank_ctrl.sv
// Double-buffered inner/middle/outer boundary RAM controller with scan-safe bank swap
// and comparator-priority read arbitration. Define REGION_INIT_EN to fill the RAMs after reset.
module region_bank_ctrl
  import region_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cycle_enable,
  input  logic          cfg_wr_en,
  input  logic [1:0]    cfg_wr_region,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [DW-1:0] cfg_wr_data,
  output logic          cfg_wr_ready,
  input  logic          cfg_commit,
  input  logic          cfg_err_clr,
  output logic          cfg_err,
  output logic          swap_pending,
  output logic          active_bank,
  output logic [7:0]    swap_cnt,
  output logic          init_done,
  input  logic          cmp_rden,
  input  logic [AW-1:0] cmp_rdaddr,
  input  logic          hst_rd_req,
  input  logic          hst_rd_shadow,
  input  logic [1:0]    hst_rd_region,
  input  logic [AW-1:0] hst_rd_addr,
  output logic          hst_rd_ack,
  output logic          hst_rd_valid,
  output logic [DW-1:0] hst_rd_data,
  output logic [2:0]    ram_wren,
  output logic [AW:0]   ram_wraddr,
  output logic [DW-1:0] ram_wrdata,
  output logic          ram_rden,
  output logic [AW:0]   ram_rdaddr,
  input  logic [DW-1:0] ram_rddata0,
  input  logic [DW-1:0] ram_rddata1,
  input  logic [DW-1:0] ram_rddata2
);
  state_t        r_state;
  logic          r_active_bank, r_pending, r_init_done, r_err;
  logic          r_ce_q, r_fall;
  logic [7:0]    r_swap_cnt;
  logic [2:0]    r_wren;
  logic [AW:0]   r_wraddr;
  logic [DW-1:0] r_wrdata;
`ifdef REGION_INIT_EN
  logic [AW-1:0] r_init_addr;
  logic          r_init_bank;
`endif

  logic w_wr_ready, w_wr_acc, w_wr_ok, w_swap_cond, w_hst_ok;

  assign w_wr_ready  = (r_state == ST_IDLE) && r_init_done;
  assign w_wr_acc    = cfg_wr_en && w_wr_ready;
  assign w_wr_ok     = addr_ok(cfg_wr_region, cfg_wr_addr);
  // Swap either one cycle after the scan ends, or immediately if the scanner is already idle.
  assign w_swap_cond = r_fall || (!cycle_enable && !r_ce_q);
  assign w_hst_ok    = addr_ok(hst_rd_region, hst_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef REGION_INIT_EN
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_bank <= 1'b0;
`else
      r_state     <= ST_IDLE;
`endif
      r_active_bank <= 1'b0;
      r_pending     <= 1'b0;
      r_init_done   <= 1'b0;
      r_err         <= 1'b0;
      r_ce_q        <= 1'b0;
      r_fall        <= 1'b0;
      r_swap_cnt    <= '0;
      r_wren        <= '0;
      r_wraddr      <= '0;
      r_wrdata      <= '0;
    end else begin
      r_ce_q <= cycle_enable;
      r_fall <= r_ce_q && !cycle_enable;
      r_wren <= '0;
      if (w_wr_acc) begin
        r_wraddr <= {~r_active_bank, cfg_wr_addr};
        r_wrdata <= cfg_wr_data;
        if (w_wr_ok) r_wren <= 3'b001 << cfg_wr_region;
      end
      if (w_wr_acc && !w_wr_ok) r_err <= 1'b1;
      else if (cfg_err_clr)     r_err <= 1'b0;
`ifndef REGION_INIT_EN
      r_init_done <= 1'b1;
`endif
      case (r_state)
`ifdef REGION_INIT_EN
        ST_INIT: begin
          r_wren   <= 3'b111;
          r_wraddr <= {r_init_bank, r_init_addr};
          r_wrdata <= FILL_VALUE;
          if (r_init_addr == AW'(NPOINTS - 1)) begin
            r_init_addr <= '0;
            r_init_bank <= 1'b1;
            if (r_init_bank) begin
              r_state     <= ST_IDLE;
              r_init_done <= 1'b1;
            end
          end else begin
            r_init_addr <= r_init_addr + 1'b1;
          end
        end
`endif
        ST_IDLE: begin
          if (cfg_commit) begin
            r_state   <= ST_ARMED;
            r_pending <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_swap_cond) begin
            r_state       <= ST_SWAP;
            r_active_bank <= ~r_active_bank;
            r_swap_cnt    <= r_swap_cnt + 8'd1;
          end
        end
        ST_SWAP: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Comparator owns the read port whenever it asks; host takes the idle slots.
  always_comb begin
    ram_rden   = 1'b0;
    ram_rdaddr = '0;
    hst_rd_ack = 1'b0;
    if (cmp_rden) begin
      ram_rden   = 1'b1;
      ram_rdaddr = {r_active_bank, cmp_rdaddr};
    end else if (hst_rd_req && r_init_done) begin
      hst_rd_ack = 1'b1;
      ram_rden   = w_hst_ok;
      ram_rdaddr = {r_active_bank ^ hst_rd_shadow, hst_rd_addr};
    end
  end

  region_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (hst_rd_ack),
    .i_region  (hst_rd_region),
    .i_ovr     (!w_hst_ok),
    .i_rddata0 (ram_rddata0),
    .i_rddata1 (ram_rddata1),
    .i_rddata2 (ram_rddata2),
    .o_vld     (hst_rd_valid),
    .o_data    (hst_rd_data)
  );

  assign cfg_wr_ready = w_wr_ready;
  assign cfg_err      = r_err;
  assign swap_pending = r_pending;
  assign active_bank  = r_active_bank;
  assign swap_cnt     = r_swap_cnt;
  assign init_done    = r_init_done;
  assign ram_wren     = r_wren;
  assign ram_wraddr   = r_wraddr;
  assign ram_wrdata   = r_wrdata;
endmodule

// File: tb/tb_region_bank_ctrl.sv
// Directed bench for region_bank_ctrl with a behavioural 2-cycle-latency RAM for all three regions.
`timescale 1ns/1ps
module tb_region_bank_ctrl;
  import region_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cycle_enable = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [1:0]    cfg_wr_region = '0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_ready;
  logic          cfg_commit = 1'b0;
  logic          cfg_err_clr = 1'b0;
  logic          cfg_err, swap_pending, active_bank, init_done;
  logic [7:0]    swap_cnt;
  logic          cmp_rden = 1'b0;
  logic [AW-1:0] cmp_rdaddr = '0;
  logic          hst_rd_req = 1'b0;
  logic          hst_rd_shadow = 1'b0;
  logic [1:0]    hst_rd_region = '0;
  logic [AW-1:0] hst_rd_addr = '0;
  logic          hst_rd_ack, hst_rd_valid;
  logic [DW-1:0] hst_rd_data;
  logic [2:0]    ram_wren;
  logic [AW:0]   ram_wraddr, ram_rdaddr;
  logic [DW-1:0] ram_wrdata;
  logic          ram_rden;
  logic [DW-1:0] ram_rddata0, ram_rddata1, ram_rddata2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  region_bank_ctrl dut (
    .clk(clk), .rst(rst), .cycle_enable(cycle_enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_region(cfg_wr_region), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_ready(cfg_wr_ready), .cfg_commit(cfg_commit),
    .cfg_err_clr(cfg_err_clr), .cfg_err(cfg_err), .swap_pending(swap_pending),
    .active_bank(active_bank), .swap_cnt(swap_cnt), .init_done(init_done),
    .cmp_rden(cmp_rden), .cmp_rdaddr(cmp_rdaddr), .hst_rd_req(hst_rd_req),
    .hst_rd_shadow(hst_rd_shadow), .hst_rd_region(hst_rd_region), .hst_rd_addr(hst_rd_addr),
    .hst_rd_ack(hst_rd_ack), .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr),
    .ram_rddata0(ram_rddata0), .ram_rddata1(ram_rddata1), .ram_rddata2(ram_rddata2)
  );

  // RAM model: write on the edge, read data two edges after rden.
  logic [DW-1:0] mem0 [2048];
  logic [DW-1:0] mem1 [2048];
  logic [DW-1:0] mem2 [2048];
  logic [DW-1:0] q1_0 = '0, q1_1 = '0, q1_2 = '0, q2_0 = '0, q2_1 = '0, q2_2 = '0;
  always @(posedge clk) begin
    if (ram_wren[0]) mem0[ram_wraddr] <= ram_wrdata;
    if (ram_wren[1]) mem1[ram_wraddr] <= ram_wrdata;
    if (ram_wren[2]) mem2[ram_wraddr] <= ram_wrdata;
    if (ram_rden) begin
      q1_0 <= mem0[ram_rdaddr];
      q1_1 <= mem1[ram_rdaddr];
      q1_2 <= mem2[ram_rdaddr];
    end
    q2_0 <= q1_0;
    q2_1 <= q1_1;
    q2_2 <= q1_2;
  end
  assign ram_rddata0 = q2_0;
  assign ram_rddata1 = q2_1;
  assign ram_rddata2 = q2_2;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] region, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
    cfg_wr_en     = 1'b1;
    cfg_wr_region = region;
    cfg_wr_addr   = addr;
    cfg_wr_data   = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int nw;
    tick();
    tick();
    check_eq("rst_init_done", 32'(init_done), 0);
    check_eq("rst_active_bank", 32'(active_bank), 0);
    check_eq("rst_swap_pending", 32'(swap_pending), 0);
    check_eq("rst_swap_cnt", 32'(swap_cnt), 0);
    check_eq("rst_cfg_err", 32'(cfg_err), 0);
    check_eq("rst_ram_wren", 32'(ram_wren), 0);
    check_eq("rst_hst_rd_valid", 32'(hst_rd_valid), 0);
    rst = 1'b0;

`ifdef REGION_INIT_EN
    n = 0;
    nw = 0;
    while (!init_done && n < 3000) begin
      if (ram_wren == 3'b111 && ram_wrdata == FILL_VALUE) nw++;
      tick();
      n++;
    end
    if (ram_wren == 3'b111 && ram_wrdata == FILL_VALUE) nw++;
    check_eq("init_cycles", 32'(n), 1624);
    check_eq("init_fill_writes", 32'(nw), 1624);
    check_eq("init_last_addr", 32'(ram_wraddr), 32'h72B);
`else
    n = 0;
    nw = 0;
    tick();
    check_eq("init_done_after_rst", 32'(init_done), 1);
`endif
    tick();
    check_eq("wr_ready_idle", 32'(cfg_wr_ready), 1);

    // Shadow-bank write lands one cycle after acceptance
    cfg_write(2'd1, 10'd5, 18'h00200);
    check_eq("wr_wren", 32'(ram_wren), 32'h2);
    check_eq("wr_wraddr", 32'(ram_wraddr), 32'h405);
    check_eq("wr_wrdata", 32'(ram_wrdata), 32'h200);
    check_eq("wr_bank_unchanged", 32'(active_bank), 0);
    cfg_write(2'd2, 10'd7, 18'h00456);
    check_eq("wr2_wraddr", 32'(ram_wraddr), 32'h407);
    tick();
    check_eq("wr_wren_clears", 32'(ram_wren), 0);

    // Illegal writes
    cfg_write(2'd0, 10'd812, 18'h00001);
    check_eq("bad_addr_wren", 32'(ram_wren), 0);
    check_eq("bad_addr_err", 32'(cfg_err), 1);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    check_eq("err_clr", 32'(cfg_err), 0);
    cfg_err_clr = 1'b1;
    cfg_write(2'd3, 10'd0, 18'h00001);
    cfg_err_clr = 1'b0;
    check_eq("region3_wren", 32'(ram_wren), 0);
    check_eq("err_beats_clr", 32'(cfg_err), 1);
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    check_eq("err_clr2", 32'(cfg_err), 0);

    // Commit during a scan waits for the scan to end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check_eq("armed_pending", 32'(swap_pending), 1);
    check_eq("armed_wr_ready", 32'(cfg_wr_ready), 0);
    tick();
    tick();
    check_eq("armed_bank_hold", 32'(active_bank), 0);
    cycle_enable = 1'b0;
    tick();
    check_eq("fall_bank_hold", 32'(active_bank), 0);
    tick();
    check_eq("swap_bank", 32'(active_bank), 1);
    check_eq("swap_cnt1", 32'(swap_cnt), 1);
    check_eq("swap_pending", 32'(swap_pending), 1);
    tick();
    check_eq("post_swap_pending", 32'(swap_pending), 0);
    check_eq("post_swap_ready", 32'(cfg_wr_ready), 1);

    cfg_write(2'd0, 10'd7, 18'h00321);
    check_eq("wr_bank0_addr", 32'(ram_wraddr), 32'h007);

    // Host read starved by comparator for three cycles
    cmp_rden = 1'b1;
    cmp_rdaddr = 10'd9;
    hst_rd_req = 1'b1;
    hst_rd_shadow = 1'b0;
    hst_rd_region = 2'd1;
    hst_rd_addr = 10'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("cmp_prio_ack", 32'(hst_rd_ack), 0);
      check_eq("cmp_rdaddr", 32'(ram_rdaddr), 32'h409);
      tick();
    end
    cmp_rden = 1'b0;
    #1;
    check_eq("hst_ack", 32'(hst_rd_ack), 1);
    check_eq("hst_rden", 32'(ram_rden), 1);
    check_eq("hst_rdaddr", 32'(ram_rdaddr), 32'h405);
    tick();
    hst_rd_req = 1'b0;
    check_eq("hst_valid_lat1", 32'(hst_rd_valid), 0);
    tick();
    check_eq("hst_valid_lat2", 32'(hst_rd_valid), 1);
    check_eq("hst_data", 32'(hst_rd_data), 32'h200);

    // Back-to-back reads: shadow, active, illegal region, illegal address
    hst_rd_req = 1'b1;
    hst_rd_shadow = 1'b1;
    hst_rd_region = 2'd0;
    hst_rd_addr = 10'd7;
    #1;
    check_eq("b2b0_rdaddr", 32'(ram_rdaddr), 32'h007);
    tick();
    hst_rd_shadow = 1'b0;
    hst_rd_region = 2'd2;
    #1;
    check_eq("b2b1_rdaddr", 32'(ram_rdaddr), 32'h407);
    check_eq("b2b1_ack", 32'(hst_rd_ack), 1);
    tick();
    hst_rd_region = 2'd3;
    hst_rd_addr = 10'd0;
    #1;
    check_eq("b2b2_ack", 32'(hst_rd_ack), 1);
    check_eq("b2b2_no_rden", 32'(ram_rden), 0);
    check_eq("b2b0_valid", 32'(hst_rd_valid), 1);
    check_eq("b2b0_data", 32'(hst_rd_data), 32'h321);
    tick();
    hst_rd_region = 2'd0;
    hst_rd_addr = 10'd900;
    #1;
    check_eq("b2b3_ack", 32'(hst_rd_ack), 1);
    check_eq("b2b3_no_rden", 32'(ram_rden), 0);
    check_eq("b2b1_data", 32'(hst_rd_data), 32'h456);
    tick();
    hst_rd_req = 1'b0;
    check_eq("b2b2_data", 32'(hst_rd_data), 32'h0FFFF);
    tick();
    check_eq("b2b3_valid", 32'(hst_rd_valid), 1);
    check_eq("b2b3_data", 32'(hst_rd_data), 32'h0FFFF);
    tick();
    check_eq("b2b_valid_done", 32'(hst_rd_valid), 0);

    // Idle scanner: commit + write together, duplicate commit ignored
    cfg_commit = 1'b1;
    cfg_write(2'd2, 10'd3, 18'h0AAAA);
    check_eq("cw_pending", 32'(swap_pending), 1);
    check_eq("cw_wren", 32'(ram_wren), 32'h4);
    check_eq("cw_wraddr", 32'(ram_wraddr), 32'h003);
    check_eq("cw_bank_before", 32'(active_bank), 1);
    tick();
    cfg_commit = 1'b0;
    check_eq("cw_bank_swapped", 32'(active_bank), 0);
    check_eq("cw_swap_cnt", 32'(swap_cnt), 2);
    tick();
    tick();
    check_eq("cw_pending_clr", 32'(swap_pending), 0);
    check_eq("cw_swap_cnt_once", 32'(swap_cnt), 2);

    // Reset mid-operation
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_bank", 32'(active_bank), 0);
    check_eq("rst2_swap_cnt", 32'(swap_cnt), 0);
    check_eq("rst2_pending", 32'(swap_pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
